block_map_module: RTL

- Owns the arena block map (ABM): one 2-bit cell code per 16-pixel tile.
- Builds the map after reset: fixed pillar grid plus LFSR-placed soft blocks.
- Serves registered cell reads to the enemy FSM (get_rand_dir/check_dir) and to the display path.
- Clears soft blocks along an explosion cross on request from the bomb logic.

---
 rtl/block_map_module_if.sv | 26 ++
 rtl/block_map_module.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/block_map_module_if.sv
// Bundle between the arena block map and its clients: enemy/display read ports,
// the explosion-clear handshake and map status.
interface block_map_module_if;
    logic [10:0] r_addr;
    logic [1:0]  r_data;
    logic [10:0] d_addr;
    logic [1:0]  d_data;
    logic        exp_start;
    logic [5:0]  exp_x;
    logic [4:0]  exp_y;
    logic [1:0]  exp_len;
    logic        exp_busy;
    logic        exp_done;
    logic        map_ready;
    logic [7:0]  cleared_cnt;

    modport master (
        output r_addr, d_addr, exp_start, exp_x, exp_y, exp_len,
        input  r_data, d_data, exp_busy, exp_done, map_ready, cleared_cnt
    );

    modport slave (
        input  r_addr, d_addr, exp_start, exp_x, exp_y, exp_len,
        output r_data, d_data, exp_busy, exp_done, map_ready, cleared_cnt
    );
endinterface

// File: rtl/block_map_module.sv
// Arena block map: builds pillar grid plus random soft blocks after reset,
// serves two registered read ports, and clears soft blocks along explosion arms.
module block_map_module #(
    parameter int          ARENA_W   = 33,
    parameter int          ARENA_H   = 27,
    parameter int          DENSITY   = 6,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    block_map_module_if.slave    bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD       = 3'd1;
    localparam logic [2:0] S_EVAL     = 3'd2;
    localparam logic [2:0] S_NEXT_DIR = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [1:0] DIR_U = 2'd0;
    localparam logic [1:0] DIR_R = 2'd1;
    localparam logic [1:0] DIR_D = 2'd2;
    localparam logic [1:0] DIR_L = 2'd3;

    localparam logic [1:0] CELL_EMPTY  = 2'b00;
    localparam logic [1:0] CELL_PILLAR = 2'b01;
    localparam logic [1:0] CELL_SOFT   = 2'b10;

    // Indexed directly by the {y,x} address; unused columns/rows are never read.
    logic [1:0]  abm_mem [0:2047];

    logic [15:0] lfsr_reg;
    logic [5:0]  init_x_reg;
    logic [4:0]  init_y_reg;
    logic        map_ready_reg;
    logic        init_last;
    logic        init_spawn;
    logic [1:0]  init_cell;

    logic [2:0]  state_reg;
    logic [5:0]  cx_reg;
    logic [4:0]  cy_reg;
    logic [1:0]  len_reg;
    logic [1:0]  dir_reg;
    logic [1:0]  k_reg;
    logic [10:0] t_addr_reg;
    logic [1:0]  ev_data_reg;
    logic        exp_busy_reg;
    logic        exp_done_reg;
    logic [7:0]  cleared_cnt_reg;
    logic [1:0]  r_data_reg;
    logic [1:0]  d_data_reg;

    logic [6:0]  tgt_x;
    logic [5:0]  tgt_y;
    logic        tgt_oob;
    logic [10:0] tgt_addr;

    logic        wr_en;
    logic [10:0] wr_addr;
    logic [1:0]  wr_data;

    logic        r_oob;
    logic        d_oob;

    assign init_last  = (init_x_reg == 6'(ARENA_W - 1)) && (init_y_reg == 5'(ARENA_H - 1));
    assign init_spawn = ((init_y_reg == 5'd0)  && (init_x_reg == 6'd0  || init_x_reg == 6'd1))  ||
                        ((init_y_reg == 5'd1)  && (init_x_reg == 6'd0))                          ||
                        ((init_y_reg == 5'd10) && (init_x_reg == 6'd10 || init_x_reg == 6'd11)) ||
                        ((init_y_reg == 5'd11) && (init_x_reg == 6'd10));

    always_comb begin
        init_cell = CELL_EMPTY;
        if (init_x_reg[0] && init_y_reg[0])
            init_cell = CELL_PILLAR;
        else if (!init_spawn && (lfsr_reg[3:0] < 4'(DENSITY)))
            init_cell = CELL_SOFT;
    end

    // Target of the current arm step; subtraction underflow wraps high and reads as out of bounds.
    always_comb begin
        tgt_x = {1'b0, cx_reg};
        tgt_y = {1'b0, cy_reg};
        case (dir_reg)
            DIR_U:   tgt_y = {1'b0, cy_reg} - {4'd0, k_reg};
            DIR_R:   tgt_x = {1'b0, cx_reg} + {5'd0, k_reg};
            DIR_D:   tgt_y = {1'b0, cy_reg} + {4'd0, k_reg};
            default: tgt_x = {1'b0, cx_reg} - {5'd0, k_reg};
        endcase
        tgt_oob  = (tgt_x >= 7'(ARENA_W)) || (tgt_y >= 6'(ARENA_H));
        tgt_addr = {tgt_y[4:0], tgt_x[5:0]};
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = t_addr_reg;
        wr_data = CELL_EMPTY;
        if (!map_ready_reg) begin
            wr_en   = 1'b1;
            wr_addr = {init_y_reg, init_x_reg};
            wr_data = init_cell;
        end else if (state_reg == S_EVAL && ev_data_reg == CELL_SOFT) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            abm_mem[wr_addr] <= wr_data;
    end

    assign r_oob = (bus.r_addr[5:0] >= 6'(ARENA_W)) || (bus.r_addr[10:6] >= 5'(ARENA_H));
    assign d_oob = (bus.d_addr[5:0] >= 6'(ARENA_W)) || (bus.d_addr[10:6] >= 5'(ARENA_H));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_reg  <= CELL_PILLAR;
            d_data_reg  <= CELL_EMPTY;
            ev_data_reg <= CELL_EMPTY;
        end else begin
            r_data_reg  <= (!map_ready_reg || r_oob) ? CELL_PILLAR : abm_mem[bus.r_addr];
            d_data_reg  <= !map_ready_reg ? CELL_EMPTY :
                           (d_oob ? CELL_PILLAR : abm_mem[bus.d_addr]);
            ev_data_reg <= abm_mem[tgt_addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_reg      <= LFSR_SEED;
            init_x_reg    <= '0;
            init_y_reg    <= '0;
            map_ready_reg <= 1'b0;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
            if (!map_ready_reg) begin
                if (init_last) begin
                    map_ready_reg <= 1'b1;
                end else if (init_x_reg == 6'(ARENA_W - 1)) begin
                    init_x_reg <= '0;
                    init_y_reg <= init_y_reg + 5'd1;
                end else begin
                    init_x_reg <= init_x_reg + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= S_IDLE;
            cx_reg          <= '0;
            cy_reg          <= '0;
            len_reg         <= 2'd1;
            dir_reg         <= DIR_U;
            k_reg           <= 2'd1;
            t_addr_reg      <= '0;
            exp_busy_reg    <= 1'b0;
            exp_done_reg    <= 1'b0;
            cleared_cnt_reg <= '0;
        end else begin
            exp_done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.exp_start && map_ready_reg) begin
                        cx_reg       <= bus.exp_x;
                        cy_reg       <= bus.exp_y;
                        len_reg      <= (bus.exp_len == 2'd0) ? 2'd1 : bus.exp_len;
                        dir_reg      <= DIR_U;
                        k_reg        <= 2'd1;
                        exp_busy_reg <= 1'b1;
                        state_reg    <= S_RD;
                    end
                end
                S_RD: begin
                    if (tgt_oob) begin
                        state_reg <= S_NEXT_DIR;
                    end else begin
                        t_addr_reg <= tgt_addr;
                        state_reg  <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (ev_data_reg == CELL_SOFT) begin
                        if (cleared_cnt_reg != 8'hFF)
                            cleared_cnt_reg <= cleared_cnt_reg + 8'd1;
                        state_reg <= S_NEXT_DIR;
                    end else if (ev_data_reg == CELL_EMPTY && k_reg != len_reg) begin
                        k_reg     <= k_reg + 2'd1;
                        state_reg <= S_RD;
                    end else begin
                        state_reg <= S_NEXT_DIR;
                    end
                end
                S_NEXT_DIR: begin
                    if (dir_reg == DIR_L) begin
                        state_reg <= S_DONE;
                    end else begin
                        dir_reg   <= dir_reg + 2'd1;
                        k_reg     <= 2'd1;
                        state_reg <= S_RD;
                    end
                end
                S_DONE: begin
                    exp_done_reg <= 1'b1;
                    exp_busy_reg <= 1'b0;
                    state_reg    <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.r_data      = r_data_reg;
    assign bus.d_data      = d_data_reg;
    assign bus.exp_busy    = exp_busy_reg;
    assign bus.exp_done    = exp_done_reg;
    assign bus.map_ready   = map_ready_reg;
    assign bus.cleared_cnt = cleared_cnt_reg;
endmodule
